rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer; successor to the single-bit 2:1 combinational mux.
- Select is no longer an external pin. An internal arbiter picks among requesting inputs, in round-robin or fixed-priority mode.
- Result is held in a one-deep output register with valid/ready handshake on every port.
- Sits between multiple producers and one shared consumer, e.g. a shared bus or result port.

Parameters:
- N_IN, 4, number of input channels (2..16)
- WIDTH, 8, data width per channel (1..64)
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority with lowest index winning

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  N_IN  per-channel request
- in_data  input  N_IN*WIDTH  packed payload; channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  N_IN  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered selected payload
- out_sel  output  SEL_W  index of the channel that supplied out_data; SEL_W = max(1, clog2(N_IN))
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready=0 while rst is high.
- load_en = ~out_valid | out_ready. The register can accept a new beat in the same cycle the old one drains.
- grant (combinational, one-hot):
  - RR_MODE=1: first asserted in_valid found searching from index rr_ptr upward, wrapping modulo N_IN.
  - RR_MODE=0: lowest asserted in_valid index.
- in_ready = grant & {N_IN{load_en}}. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer, the next edge sets out_data = in_data[i], out_sel = i, out_valid = 1.
- RR_MODE=1 only: rr_ptr = (i+1) mod N_IN on a transfer. Wrap from N_IN-1 to 0. rr_ptr is unchanged when no transfer occurs.
- If out_valid & out_ready and no input is valid, the next edge clears out_valid to 0. out_data and out_sel hold their last values.
- If out_valid & ~out_ready (stall), out_data and out_sel are held, in_ready=0, and no grant is issued.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high.
- Simultaneous requests: exactly one grant per cycle. Losing inputs must keep in_valid and in_data stable until granted; the block does not check this.
- Fairness: in RR mode, with all inputs continuously valid and out_ready=1, grant order is 0,1,...,N_IN-1,0,...
- No combinational path from out_ready to out_data. There is a combinational path from out_ready to in_ready; this is permitted.
- Reset mid-operation: the pending output beat is discarded (out_valid=0) and rr_ptr returns to 0 on the same edge.
- No input valid and output empty: out_valid stays 0 and all registers hold.

Decomposition:
- Shared package mux_pkg holds:
  - clog2 constant function
  - SEL_W derivation
  - arbitration mode constants RR and FIXED
- One sub-module, rr_arbiter: holds rr_ptr, the grant logic and the pointer update.
  - Ports: clk, rst, req[N_IN], adv, grant[N_IN], grant_idx.
  - Parametrised on N_IN and RR_MODE.
- The top level contains only load_en, the data select and the output register.

Test Plan:
1. Reset and idle: hold rst=1 for 2 cycles with all in_valid high, then release with in_valid=0 → out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
2. Single channel (N_IN=4, WIDTH=8): in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
3. RR fairness (RR_MODE=1): all in_valid=1, channel i data = 8'h10+i, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3; out_data sequence 10,11,12,13,10,11,12,13.
4. Fixed priority (RR_MODE=0): in_valid=4'b1010 held for 3 cycles → out_sel=1 every cycle; channel 3 never granted.
5. Backpressure: output holds 8'h11 from channel 1; out_ready=0 for 3 cycles while in_valid=4'b1111 → out_data stays 8'h11, in_ready=0, rr_ptr stays 2. On out_ready=1, the grant goes to channel 2 and out_sel=2 the next cycle.
6. Reset mid-stream: assert rst for 1 cycle while out_valid=1 and rr_ptr=3 → next cycle out_valid=0. The first grant after reset with all inputs valid goes to channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin / fixed-priority mux.
package mux_pkg;

  // Arbitration mode selectors for the RR_MODE parameter.
  localparam bit RR    = 1'b1;
  localparam bit FIXED = 1'b0;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter with a round-robin pointer (or fixed lowest-index priority).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N_IN    = 4,
  parameter  bit RR_MODE = RR,
  localparam int SEL_W   = sel_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req,
  input  logic             adv,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] rr_ptr;

  // Search for the first request starting at rr_ptr (RR) or at 0 (fixed), wrapping modulo N_IN.
  always_comb begin
    int  base;
    int  j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    base      = (RR_MODE == RR) ? int'(rr_ptr) : 0;
    for (int k = 0; k < N_IN; k++) begin
      j = base + k;
      if (j >= N_IN) j = j - N_IN;
      if (!found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = SEL_W'(j);
        found     = 1'b1;
      end
    end
  end

  // After a transfer the winner's successor gets first look next time; idle cycles leave the pointer alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((RR_MODE == RR) && adv) begin
      rr_ptr <= (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-input registered mux: the internal arbiter picks a requester, the winner's
// payload lands in a one-deep output register.
//
// Handshake: every port uses valid/ready. A beat moves when valid and ready are
// both high at a rising edge. Producers hold valid and data stable until ready;
// valid never depends on ready. in_ready may depend combinationally on out_ready,
// but out_data/out_sel/out_valid come straight from flops.
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter  int N_IN    = 4,
  parameter  int WIDTH   = 8,
  parameter  bit RR_MODE = RR,
  localparam int SEL_W   = sel_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  logic             load_en;
  logic             adv;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;

  // The register can take a new beat when empty or when its current beat drains this cycle.
  assign load_en  = ~out_valid | out_ready;
  assign in_ready = rst ? '0 : (grant & {N_IN{load_en}});
  assign adv      = |(in_valid & in_ready);

  rr_arbiter #(
    .N_IN    (N_IN),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .adv       (adv),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot select of the granted channel's payload.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register: load on transfer, drop valid when drained with nothing new, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench: one round-robin instance and one fixed-priority instance,
// each with an expected-beat queue drained by its own monitor.
module tb_rr_mux_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam int QW = SW + W;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] in_data;

  logic [N-1:0] rr_valid, rr_in_ready;
  logic         rr_out_valid, rr_out_ready;
  logic [W-1:0] rr_out_data;
  logic [SW-1:0] rr_out_sel;

  logic [N-1:0] fx_valid, fx_in_ready;
  logic         fx_out_valid, fx_out_ready;
  logic [W-1:0] fx_out_data;
  logic [SW-1:0] fx_out_sel;

  int checks = 0;
  int errors = 0;

  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] fx_exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  rr_mux_arb #(.N_IN(N), .WIDTH(W), .RR_MODE(1'b1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rr_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_ready (rr_out_ready)
  );

  rr_mux_arb #(.N_IN(N), .WIDTH(W), .RR_MODE(1'b0)) dut_fx (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fx_valid),
    .in_data   (in_data),
    .in_ready  (fx_in_ready),
    .out_valid (fx_out_valid),
    .out_data  (fx_out_data),
    .out_sel   (fx_out_sel),
    .out_ready (fx_out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // scoreboard monitor for the round-robin instance
  always @(negedge clk) begin
    if (!rst && rr_out_valid && rr_out_ready) begin
      if (exp_q.size() == 0) begin
        check("rr_unexpected_beat", {22'd0, rr_out_sel, rr_out_data}, 32'hFFFF_FFFF);
      end else begin
        check("rr_beat", {22'd0, rr_out_sel, rr_out_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // scoreboard monitor for the fixed-priority instance
  always @(negedge clk) begin
    if (!rst && fx_out_valid && fx_out_ready) begin
      if (fx_exp_q.size() == 0) begin
        check("fx_unexpected_beat", {22'd0, fx_out_sel, fx_out_data}, 32'hFFFF_FFFF);
      end else begin
        check("fx_beat", {22'd0, fx_out_sel, fx_out_data}, {22'd0, fx_exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst          = 1'b1;
    rr_valid     = 4'hF;
    rr_out_ready = 1'b1;
    fx_valid     = 4'h0;
    fx_out_ready = 1'b1;
    in_data      = '0;

    // 1. reset with requests present, then idle
    repeat (2) begin
      sample();
      check("rst_in_ready", {28'd0, rr_in_ready}, 32'h0);
      check("rst_out_valid", {31'd0, rr_out_valid}, 32'h0);
    end
    step();
    rst      = 1'b0;
    rr_valid = 4'h0;
    sample();
    check("idle_out_valid", {31'd0, rr_out_valid}, 32'h0);
    check("idle_out_data", {24'd0, rr_out_data}, 32'h0);
    check("idle_out_sel", {30'd0, rr_out_sel}, 32'h0);
    check("idle_in_ready", {28'd0, rr_in_ready}, 32'h0);

    // 2. single channel 2
    step();
    rr_valid = 4'b0100;
    in_data  = 32'h00A5_0000;
    sample();
    check("single_in_ready", {28'd0, rr_in_ready}, 32'h4);
    exp_q.push_back({2'd2, 8'hA5});
    step();
    rr_valid = 4'h0;
    sample();
    step();
    sample();
    check("drain_out_valid", {31'd0, rr_out_valid}, 32'h0);
    check("hold_out_data", {24'd0, rr_out_data}, 32'hA5);

    // pointer back to 0 before the fairness run
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 3. round-robin fairness with all channels requesting
    in_data  = 32'h1312_1110;
    rr_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("rr_in_ready", {28'd0, rr_in_ready}, 32'(1 << (k % 4)));
      exp_q.push_back({2'(k % 4), 8'(8'h10 + k % 4)});
      step();
    end
    rr_valid = 4'h0;
    sample();
    step();

    // 5. backpressure: ch1 beat stalls, pointer parked at 2
    rr_valid = 4'b0010;
    sample();
    check("bp_load_in_ready", {28'd0, rr_in_ready}, 32'h2);
    exp_q.push_back({2'd1, 8'h11});
    step();
    rr_out_ready = 1'b0;
    rr_valid     = 4'hF;
    repeat (3) begin
      sample();
      check("stall_in_ready", {28'd0, rr_in_ready}, 32'h0);
      check("stall_out_valid", {31'd0, rr_out_valid}, 32'h1);
      check("stall_out_data", {24'd0, rr_out_data}, 32'h11);
      check("stall_out_sel", {30'd0, rr_out_sel}, 32'h1);
      check("stall_rr_ptr", {30'd0, dut_rr.u_arb.rr_ptr}, 32'h2);
      step();
    end
    rr_out_ready = 1'b1;
    sample();
    check("release_in_ready", {28'd0, rr_in_ready}, 32'h4);
    step();

    // 6. reset while a ch2 beat is pending and pointer is 3
    rst          = 1'b1;
    rr_out_ready = 1'b0;
    sample();
    check("pre_rst_out_valid", {31'd0, rr_out_valid}, 32'h1);
    check("pre_rst_out_sel", {30'd0, rr_out_sel}, 32'h2);
    check("pre_rst_out_data", {24'd0, rr_out_data}, 32'h12);
    check("pre_rst_rr_ptr", {30'd0, dut_rr.u_arb.rr_ptr}, 32'h3);
    step();
    rst          = 1'b0;
    rr_out_ready = 1'b1;
    sample();
    check("post_rst_out_valid", {31'd0, rr_out_valid}, 32'h0);
    check("post_rst_rr_ptr", {30'd0, dut_rr.u_arb.rr_ptr}, 32'h0);
    check("post_rst_in_ready", {28'd0, rr_in_ready}, 32'h1);
    exp_q.push_back({2'd0, 8'h10});
    step();
    rr_valid = 4'h0;
    sample();
    step();

    // 4. fixed priority: channels 1 and 3 requesting, 1 always wins
    fx_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("fx_in_ready", {28'd0, fx_in_ready}, 32'h2);
      fx_exp_q.push_back({2'd1, 8'h11});
      step();
    end
    fx_valid = 4'h0;
    sample();
    step();
    sample();
    check("fx_drain_out_valid", {31'd0, fx_out_valid}, 32'h0);

    // final report
    step();
    check("rr_queue_empty", 32'(exp_q.size()), 32'h0);
    check("fx_queue_empty", 32'(fx_exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
